// File: rtl/music_sfx_sequencer_pkg.sv
// Shared types and constants for music_sfx_sequencer: FSM states, output codes,
// the per-effect duration table and the background-code filter.
package music_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_e;

  localparam logic [3:0] STATE_SILENT = 4'd0;
  localparam logic [3:0] SFX_BASE     = 4'd8;
  localparam logic [1:0] PITCH_RESET  = 2'd1;

  // Beats per effect, indexed by request line; every entry must be 1..15.
  localparam logic [3:0] SFX_BEATS [0:7] = '{
    4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2
  };

  function automatic logic [3:0] bgm_code(input logic [3:0] bgm);
    return ((bgm >= 4'd1) && (bgm <= 4'd7)) ? bgm : STATE_SILENT;
  endfunction

endpackage

// File: rtl/music_sfx_sequencer_fifo.sv
// sfx_fifo: small synchronous FIFO for queued effect indices. A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module sfx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_FULL) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data   = mem_q[rd_ptr_q];
  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == '0);
  assign count_next = count_d;

endmodule

// File: rtl/music_sfx_sequencer.sv
// music_sfx_sequencer: arbitrates SFX requests and background music into gene_music's
// state/pitch inputs. Define MUSIC_SEQ_MUTE_EN to add the mute input.
module music_sfx_sequencer
  import music_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BEAT_HZ    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_EVT    = 8,
  parameter int GAP_BEATS  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] evt_req,
  input  logic [3:0]         bgm_state,
  input  logic               pitch_up,
  input  logic               pitch_down,
  output logic [3:0]         state,
  output logic [1:0]         pitch,
  output logic               busy,
  output logic               drop
`ifdef MUSIC_SEQ_MUTE_EN
  ,
  input  logic               mute
`endif
);

  localparam int DIV   = CLK_HZ / BEAT_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0]       GAP_LOAD = 4'(GAP_BEATS);

  seq_state_e fsm_q, fsm_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       beat_q, beat_d;
  logic [3:0]       gap_q, gap_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       state_q, state_d, state_core;
  logic [1:0]       pitch_q, pitch_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;

  logic             req_valid, req_extra;
  logic [2:0]       req_idx;
  logic             tick, div_restart;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [2:0]       fifo_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_next;

  // Lowest set request bit wins; any other bit set in the same cycle is dropped.
  always_comb begin
    req_valid = |evt_req;
    req_idx   = '0;
    for (int i = NUM_EVT - 1; i >= 0; i--) begin
      if (evt_req[i]) begin
        req_idx = 3'(i);
      end
    end
    req_extra = |(evt_req & (evt_req - NUM_EVT'(1)));
  end

  assign fifo_pop = (fsm_q == ST_IDLE) && !fifo_empty;

  sfx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (req_valid),
    .push_data  (req_idx),
    .pop        (fifo_pop),
    .pop_data   (fifo_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count_next (fifo_count_next)
  );

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    fsm_d       = fsm_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    div_restart = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          fsm_d       = ST_PLAY;
          idx_d       = fifo_data;
          beat_d      = SFX_BEATS[fifo_data];
          div_restart = 1'b1;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (beat_q == 4'd1) begin
            if (GAP_BEATS > 0) begin
              fsm_d       = ST_GAP;
              gap_d       = GAP_LOAD;
              div_restart = 1'b1;
            end else begin
              fsm_d = ST_IDLE;
            end
          end else begin
            beat_d = beat_q - 4'd1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q == 4'd1) begin
            fsm_d = ST_IDLE;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Restarting on pop and gap entry keeps the first beat of each phase full length.
  always_comb begin
    div_d = div_q + 1'b1;
    if (div_restart || tick) begin
      div_d = '0;
    end
  end

  // Outputs are registered, so they are computed from the next FSM state.
  always_comb begin
    case (fsm_d)
      ST_PLAY: state_core = SFX_BASE + {1'b0, idx_d};
      ST_GAP:  state_core = STATE_SILENT;
      default: state_core = bgm_code(bgm_state);
    endcase
`ifdef MUSIC_SEQ_MUTE_EN
    state_d = mute ? STATE_SILENT : state_core;
`else
    state_d = state_core;
`endif
    busy_d = (fsm_d != ST_IDLE) || (fifo_count_next != '0);
    drop_d = req_extra || (req_valid && fifo_full && !fifo_pop);
  end

  always_comb begin
    pitch_d = pitch_q;
    if (pitch_up && !pitch_down && (pitch_q != 2'd3)) begin
      pitch_d = pitch_q + 2'd1;
    end else if (pitch_down && !pitch_up && (pitch_q != 2'd0)) begin
      pitch_d = pitch_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= ST_IDLE;
      idx_q   <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      div_q   <= '0;
      state_q <= STATE_SILENT;
      pitch_q <= PITCH_RESET;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      div_q   <= div_d;
      state_q <= state_d;
      pitch_q <= pitch_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign state = state_q;
  assign pitch = pitch_q;
  assign busy  = busy_q;
  assign drop  = drop_q;

endmodule

// File: tb/tb_music_sfx_sequencer.sv
// Self-checking bench for music_sfx_sequencer: directed tables and sequences plus a
// randomized phase, all compared against a cycle-budget reference model.
module tb_music_sfx_sequencer;

  localparam int CLK_HZ     = 160;
  localparam int BEAT_HZ    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int NUM_EVT    = 8;
  localparam int GAP_BEATS  = 1;
  localparam int BEAT_CYC   = CLK_HZ / BEAT_HZ;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] evt_req;
  logic [3:0] bgm_state;
  logic       pitch_up;
  logic       pitch_down;
  logic [3:0] state;
  logic [1:0] pitch;
  logic       busy;
  logic       drop;
`ifdef MUSIC_SEQ_MUTE_EN
  logic       mute;
`endif

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  int beats_tbl [8] = '{2, 1, 3, 2, 1, 2, 1, 2};

  music_sfx_sequencer #(
    .CLK_HZ     (CLK_HZ),
    .BEAT_HZ    (BEAT_HZ),
    .FIFO_DEPTH (FIFO_DEPTH),
    .NUM_EVT    (NUM_EVT),
    .GAP_BEATS  (GAP_BEATS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .evt_req    (evt_req),
    .bgm_state  (bgm_state),
    .pitch_up   (pitch_up),
    .pitch_down (pitch_down),
    .state      (state),
    .pitch      (pitch),
    .busy       (busy),
    .drop       (drop)
`ifdef MUSIC_SEQ_MUTE_EN
    ,
    .mute       (mute)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a queue of effect indices and a count of cycles left in the
  // current play or gap phase. ph: 0 idle, 1 playing, 2 gap.
  int q[$];
  int ph, remain, cur;
  int m_state, m_pitch, m_busy, m_drop;

  task automatic model_step();
    bit pop_now;
    bit muted;
    int win;
    int extra;
    pop_now = (ph == 0) && (q.size() > 0);
    win   = -1;
    extra = 0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (evt_req[i]) begin
        if (win < 0) win = i;
        else extra++;
      end
    end
    m_drop = (extra > 0) ? 1 : 0;
    if (pop_now) begin
      cur    = q.pop_front();
      ph     = 1;
      remain = beats_tbl[cur] * BEAT_CYC;
    end else if (ph != 0) begin
      remain--;
      if (remain == 0) begin
        if (ph == 1 && GAP_BEATS > 0) begin
          ph     = 2;
          remain = GAP_BEATS * BEAT_CYC;
        end else begin
          ph = 0;
        end
      end
    end
    if (win >= 0) begin
      if (q.size() < FIFO_DEPTH) q.push_back(win);
      else m_drop = 1;
    end
    muted = 1'b0;
`ifdef MUSIC_SEQ_MUTE_EN
    muted = mute;
`endif
    if (muted || ph == 2) m_state = 0;
    else if (ph == 1) m_state = 8 + cur;
    else m_state = (bgm_state >= 1 && bgm_state <= 7) ? int'(bgm_state) : 0;
    if (pitch_up && !pitch_down) m_pitch = (m_pitch < 3) ? m_pitch + 1 : 3;
    else if (pitch_down && !pitch_up) m_pitch = (m_pitch > 0) ? m_pitch - 1 : 0;
    m_busy = (ph != 0 || q.size() > 0) ? 1 : 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      ph = 0; remain = 0; cur = 0;
      m_state = 0; m_pitch = 1; m_busy = 0; m_drop = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && model_on) begin
      check_output("model_state", state, m_state);
      check_output("model_pitch", pitch, m_pitch);
      check_output("model_busy", busy, m_busy);
      check_output("model_drop", drop, m_drop);
    end
  end

  // Called at a falling edge; returns at the falling edge of the following cycle.
  task automatic apply_stimulus(input logic [7:0] req);
    evt_req = req;
    @(negedge clk);
    evt_req = 8'd0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_output(name, (n < 500), 1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] req;
    int         exp_state;
    logic       exp_drop;
  } intake_vec_t;

  typedef struct {
    logic       up;
    logic       down;
    logic [1:0] exp_pitch;
  } pitch_vec_t;

  intake_vec_t iv [5];
  pitch_vec_t  pv [8];
  int          exp_order [5] = '{7, 3, 4, 5, 6};
  int          reqs [5] = '{3, 4, 5, 6, 1};

  initial begin
    int n;
    int n10;
    int ndrop;
    int prev;
    int seq_q[$];

    iv[0] = '{8'h01, 8,  1'b0};
    iv[1] = '{8'h80, 15, 1'b0};
    iv[2] = '{8'hA0, 13, 1'b1};
    iv[3] = '{8'h18, 11, 1'b1};
    iv[4] = '{8'hFF, 8,  1'b1};

    pv[0] = '{1'b1, 1'b0, 2'd2};
    pv[1] = '{1'b1, 1'b0, 2'd3};
    pv[2] = '{1'b1, 1'b0, 2'd3};
    pv[3] = '{1'b1, 1'b1, 2'd3};
    pv[4] = '{1'b0, 1'b1, 2'd2};
    pv[5] = '{1'b0, 1'b1, 2'd1};
    pv[6] = '{1'b0, 1'b1, 2'd0};
    pv[7] = '{1'b0, 1'b1, 2'd0};

    evt_req = 8'd0; bgm_state = 4'd3; pitch_up = 1'b0; pitch_down = 1'b0;
`ifdef MUSIC_SEQ_MUTE_EN
    mute = 1'b0;
`endif
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    check_output("reset_state", state, 0);
    check_output("reset_pitch", pitch, 1);
    check_output("reset_busy", busy, 0);
    check_output("reset_drop", drop, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_on = 1'b1;
    @(negedge clk);
    check_output("bgm_after_reset", state, 3);

    // Single request from idle: latency, play length and gap length.
    bgm_state = 4'd5;
    @(negedge clk);
    apply_stimulus(8'b0000_0100);
    check_output("latency_n1", state, 5);
    @(negedge clk);
    n = 0;
    while (state === 4'd10 && n < 100) begin n++; @(negedge clk); end
    check_output("sfx2_len", n, 30);
    n = 0;
    while (state === 4'd0 && n < 100) begin n++; @(negedge clk); end
    check_output("gap_len", n, 10);
    check_output("back_to_bgm", state, 5);

    for (int i = 0; i < 5; i++) begin
      wait_idle($sformatf("intake%0d_idle", i));
      apply_stimulus(iv[i].req);
      check_output($sformatf("intake%0d_drop", i), drop, iv[i].exp_drop);
      @(negedge clk);
      check_output($sformatf("intake%0d_state", i), state, iv[i].exp_state);
    end

    // Two bits at once: effect 1 plays, effect 2 is discarded.
    wait_idle("multi_idle");
    apply_stimulus(8'b0000_0110);
    check_output("multi_drop", drop, 1);
    @(negedge clk);
    check_output("multi_winner", state, 9);
    n10 = 0; ndrop = 0;
    for (int k = 0; k < 100; k++) begin
      if (state === 4'd10) n10++;
      if (drop === 1'b1) ndrop++;
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    check_output("multi_loser_plays", n10, 0);
    check_output("multi_extra_drops", ndrop, 0);

    // Five requests while effect 7 plays: four queue, the fifth overflows.
    wait_idle("fifo_idle");
    apply_stimulus(8'h80);
    seq_q.delete();
    ndrop = 0;
    prev = -1;
    n = 0;
    for (int k = 0; k < 400; k++) begin
      evt_req = (k < 5) ? (8'd1 << reqs[k]) : 8'd0;
      @(negedge clk);
      n = k;
      if (drop === 1'b1) ndrop++;
      if (state >= 4'd8 && int'(state) != prev) seq_q.push_back(int'(state) - 8);
      prev = int'(state);
      if (k > 5 && busy === 1'b0) break;
    end
    evt_req = 8'd0;
    check_output("fifo_done", (n < 399), 1);
    check_output("fifo_drops", ndrop, 1);
    check_output("fifo_order_len", seq_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < seq_q.size()) check_output($sformatf("fifo_order%0d", i), seq_q[i], exp_order[i]);
    end

    // Asynchronous reset in the middle of an effect.
    wait_idle("rst_idle");
    bgm_state = 4'd3;
    pitch_up = 1'b1;
    apply_stimulus(8'b0000_0100);
    pitch_up = 1'b0;
    repeat (5) @(negedge clk);
    check_output("rst_pre_state", state, 10);
    check_output("rst_pre_pitch", pitch, 2);
    #2 reset = 1'b0;
    #1;
    check_output("rst_mid_state", state, 0);
    check_output("rst_mid_pitch", pitch, 1);
    check_output("rst_mid_busy", busy, 0);
    check_output("rst_mid_drop", drop, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("rst_release_bgm", state, 3);

    for (int i = 0; i < 8; i++) begin
      pitch_up   = pv[i].up;
      pitch_down = pv[i].down;
      @(negedge clk);
      check_output($sformatf("pitch_vec%0d", i), pitch, pv[i].exp_pitch);
    end
    pitch_up = 1'b0;
    pitch_down = 1'b0;

`ifdef MUSIC_SEQ_MUTE_EN
    // Mute silences the output but the effect still ends on its own beat.
    wait_idle("mute_idle");
    apply_stimulus(8'b0000_0100);
    @(negedge clk);
    check_output("mute_sfx_start", state, 10);
    for (int c = 0; c < 40; c++) begin
      mute = (c >= 5 && c <= 9);
      @(negedge clk);
      if (c + 1 == 7)  check_output("mute_silent", state, 0);
      if (c + 1 == 29) check_output("mute_resumed", state, 10);
      if (c + 1 == 30) check_output("mute_end_on_beat", state, 0);
      if (c + 1 == 40) check_output("mute_gap_over", state, 3);
    end
    mute = 1'b0;
`endif

    for (int k = 0; k < 3000; k++) begin
      evt_req = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'd0;
      if ($urandom_range(0, 29) == 0) bgm_state = 4'($urandom);
      pitch_up   = ($urandom_range(0, 7) == 0);
      pitch_down = ($urandom_range(0, 7) == 0);
`ifdef MUSIC_SEQ_MUTE_EN
      if ($urandom_range(0, 19) == 0) mute = ~mute;
`endif
      @(negedge clk);
    end
    evt_req = 8'd0;
    pitch_up = 1'b0;
    pitch_down = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
